// File: rtl/glue_pkg.sv
// Shared definitions for the glue FPGA blocks.
package glue_pkg;

  localparam logic [7:0] SPI_IDLE_BYTE = 8'hFF;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SHIFT
  } spi_state_t;

endpackage

// File: rtl/sync_edge.sv
// Multi-stage synchronizer for one asynchronous pin with single-cycle rise/fall strobes.
module sync_edge #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic        RST_VAL     = 1'b0
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_q,
  output logic o_rise,
  output logic o_fall
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync <= {SYNC_STAGES{RST_VAL}};
      r_prev <= RST_VAL;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_d};
      r_prev <= r_sync[SYNC_STAGES-1];
    end
  end

  assign o_q    = r_sync[SYNC_STAGES-1];
  assign o_rise = r_sync[SYNC_STAGES-1] & ~r_prev;
  assign o_fall = ~r_sync[SYNC_STAGES-1] & r_prev;

endmodule

// File: rtl/spi_responder.sv
// SPI mode-0 slave, MSB first, oversampled in sysclk; rx strobes out, tx via a one-entry holding register.
module spi_responder
  import glue_pkg::*;
#(
  parameter logic [7:0]  IDLE_BYTE   = SPI_IDLE_BYTE,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       sysclk,
  input  logic       sysrst_n,
  input  logic       spi_sck,
  input  logic       spi_mosi,
  input  logic       spi_ss,
  output logic       spi_miso,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx_underrun,
  output logic       busy
);

  spi_state_t r_state, w_state_next;

  logic                   w_sck_level_unused, w_sck_rise, w_sck_fall;
  logic                   w_ss_q, w_ss_rise, w_ss_fall;
  logic [SYNC_STAGES-1:0] r_mosi_sync;
  logic                   w_mosi;

  logic       w_load, w_rx_edge, w_tx_edge, w_do_load, w_capture;
  logic [2:0] r_bitcnt;
  logic       r_reload;
  logic [6:0] r_rxsh;
  logic [7:0] r_txsh;
  logic [7:0] r_hold;
  logic       r_full;
  logic [7:0] r_rx_data;
  logic       r_rx_valid;
  logic       r_underrun;

  sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sck (
    .i_clk  (sysclk),
    .i_rst_n(sysrst_n),
    .i_d    (spi_sck),
    .o_q    (w_sck_level_unused),
    .o_rise (w_sck_rise),
    .o_fall (w_sck_fall)
  );

  // Select idles high, so the chain resets high and no fall strobe follows reset.
  sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_ss (
    .i_clk  (sysclk),
    .i_rst_n(sysrst_n),
    .i_d    (spi_ss),
    .o_q    (w_ss_q),
    .o_rise (w_ss_rise),
    .o_fall (w_ss_fall)
  );

  always_ff @(posedge sysclk or negedge sysrst_n) begin
    if (!sysrst_n) r_mosi_sync <= '0;
    else           r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], spi_mosi};
  end
  assign w_mosi = r_mosi_sync[SYNC_STAGES-1];

  always_ff @(posedge sysclk or negedge sysrst_n) begin
    if (!sysrst_n) r_state <= IDLE;
    else           r_state <= w_state_next;
  end

  // A select release outranks any sck edge seen in the same cycle.
  always_comb begin
    w_state_next = r_state;
    w_load       = 1'b0;
    w_rx_edge    = 1'b0;
    w_tx_edge    = 1'b0;
    if (w_ss_rise) begin
      w_state_next = IDLE;
    end else begin
      unique case (r_state)
        IDLE:    if (w_ss_fall) w_state_next = LOAD;
        LOAD: begin
          w_load       = 1'b1;
          w_state_next = SHIFT;
        end
        SHIFT: begin
          w_rx_edge = w_sck_rise;
          w_tx_edge = w_sck_fall;
        end
        default: w_state_next = IDLE;
      endcase
    end
  end

  assign w_do_load = w_load | (w_tx_edge & r_reload);
  assign w_capture = tx_valid & ~r_full;

  always_ff @(posedge sysclk or negedge sysrst_n) begin
    if (!sysrst_n) begin
      r_bitcnt   <= '0;
      r_reload   <= 1'b0;
      r_rxsh     <= '0;
      r_txsh     <= '0;
      r_hold     <= '0;
      r_full     <= 1'b0;
      r_rx_data  <= '0;
      r_rx_valid <= 1'b0;
      r_underrun <= 1'b0;
    end else begin
      r_rx_valid <= 1'b0;
      r_underrun <= 1'b0;

      if (r_state == IDLE) begin
        r_bitcnt <= '0;
        r_reload <= 1'b0;
      end else if (w_rx_edge) begin
        r_rxsh   <= {r_rxsh[5:0], w_mosi};
        r_bitcnt <= r_bitcnt + 3'd1;
        if (r_bitcnt == 3'd7) begin
          r_rx_data  <= {r_rxsh, w_mosi};
          r_rx_valid <= 1'b1;
          r_reload   <= 1'b1;
        end
      end else if (w_tx_edge && r_reload) begin
        r_reload <= 1'b0;
      end

      // A load sees the pre-edge holding state; a same-cycle capture is kept for the next load.
      if (w_do_load) begin
        if (r_full) begin
          r_txsh <= r_hold;
          r_full <= 1'b0;
        end else begin
          r_txsh     <= IDLE_BYTE;
          r_underrun <= 1'b1;
        end
      end else if (w_tx_edge) begin
        r_txsh <= {r_txsh[6:0], 1'b0};
      end

      if (w_capture) begin
        r_hold <= tx_data;
        r_full <= 1'b1;
      end
    end
  end

  assign spi_miso    = (r_state == SHIFT && !w_ss_q) ? r_txsh[7] : 1'bz;
  assign rx_data     = r_rx_data;
  assign rx_valid    = r_rx_valid;
  assign tx_ready    = ~r_full;
  assign tx_underrun = r_underrun;
  assign busy        = ~w_ss_q;

endmodule
